// File: rtl/noc_pkg.sv
// Shared constants and helpers for the 4x4 XY-routed mesh: flit field layout,
// port indices and the dimension-ordered route function.
package noc_pkg;

  localparam int BUS_WIDTH_DEF = 32;
  localparam int MESH          = 4;
  localparam int NODES         = MESH * MESH;
  localparam int NUM_PORTS     = 5;

  // Field positions counted down from the flit MSB, so any width >= 8 works.
  localparam int VLD_OFS = 0;
  localparam int ROW_OFS = 1;
  localparam int COL_OFS = 3;

  typedef enum logic [2:0] {
    P_L = 3'd0,
    P_N = 3'd1,
    P_E = 3'd2,
    P_S = 3'd3,
    P_W = 3'd4
  } port_e;

  function automatic port_e xy_route(input int row, input int col,
                                     input logic [1:0] dst_row,
                                     input logic [1:0] dst_col);
    if (int'(dst_col) > col)      return P_E;
    else if (int'(dst_col) < col) return P_W;
    else if (int'(dst_row) > row) return P_S;
    else if (int'(dst_row) < row) return P_N;
    else                          return P_L;
  endfunction

  // Index of the link leaving `node` through mesh port `dir` (N/E/S/W only).
  function automatic int link_idx(input int node, input port_e dir);
    return node * (NUM_PORTS - 1) + int'(dir) - 1;
  endfunction

endpackage

// File: rtl/noc_link_if.sv
// One-direction flit link: the sender offers a flit (bit MSB = valid), the
// receiver reports a registered ready that means "my slot is empty".
interface noc_link_if #(parameter int W = noc_pkg::BUS_WIDTH_DEF);
  logic [W-1:0] flit;
  logic         ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);
endinterface

// File: rtl/noc_router.sv
// Single mesh router: five one-flit input slots, XY route compute, one
// round-robin arbiter per output and the crossbar; local eject is registered.
module noc_router
  import noc_pkg::*;
#(
  parameter int ROW       = 0,
  parameter int COL       = 0,
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
  input logic        clk1,
  input logic        rst,
  noc_link_if.slave  in_l,
  noc_link_if.slave  in_n,
  noc_link_if.slave  in_e,
  noc_link_if.slave  in_s,
  noc_link_if.slave  in_w,
  noc_link_if.master out_l,
  noc_link_if.master out_n,
  noc_link_if.master out_e,
  noc_link_if.master out_s,
  noc_link_if.master out_w
);

  localparam int VLD    = BUS_WIDTH - 1 - VLD_OFS;
  localparam int ROW_HI = BUS_WIDTH - 1 - ROW_OFS;
  localparam int COL_HI = BUS_WIDTH - 1 - COL_OFS;

  typedef logic [BUS_WIDTH-1:0] flit_t;

  flit_t                slot_q   [NUM_PORTS];
  flit_t                slot_d   [NUM_PORTS];
  logic [2:0]           ptr_q    [NUM_PORTS];
  logic [2:0]           ptr_d    [NUM_PORTS];
  flit_t                eject_q;
  flit_t                eject_d;
  flit_t                in_flit  [NUM_PORTS];
  flit_t                out_flit [NUM_PORTS];
  port_e                route    [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_rdy;
  logic [NUM_PORTS-1:0] grant;

  assign in_flit[P_L] = in_l.flit;
  assign in_flit[P_N] = in_n.flit;
  assign in_flit[P_E] = in_e.flit;
  assign in_flit[P_S] = in_s.flit;
  assign in_flit[P_W] = in_w.flit;

  // Ready is the registered empty flag, so no ready path crosses a router.
  assign in_l.ready = ~slot_q[P_L][VLD];
  assign in_n.ready = ~slot_q[P_N][VLD];
  assign in_e.ready = ~slot_q[P_E][VLD];
  assign in_s.ready = ~slot_q[P_S][VLD];
  assign in_w.ready = ~slot_q[P_W][VLD];

  assign out_rdy = {out_w.ready, out_s.ready, out_e.ready, out_n.ready, out_l.ready};

  assign out_l.flit = eject_q;
  assign out_n.flit = out_flit[P_N];
  assign out_e.flit = out_flit[P_E];
  assign out_s.flit = out_flit[P_S];
  assign out_w.flit = out_flit[P_W];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = xy_route(ROW, COL, slot_q[i][ROW_HI -: 2], slot_q[i][COL_HI -: 2]);
    end
  end

  // Arbitration and crossbar: each output scans slots starting at its pointer.
  always_comb begin
    logic       found;
    logic [2:0] win;
    logic [2:0] cand;
    logic [3:0] sum;
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default before any branch, which is what keeps latches from forming.
    ptr_d    = ptr_q;
    grant    = '0;
    out_flit = '{default: '0};
    eject_d  = eject_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      found = 1'b0;
      win   = 3'd0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        sum  = {1'b0, ptr_q[o]} + 4'(k);
        cand = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
        if (!found && slot_q[cand][VLD] && route[cand] == port_e'(o)) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found && out_rdy[o]) begin
        grant[win]  = 1'b1;
        out_flit[o] = slot_q[win];
        ptr_d[o]    = (win == 3'(NUM_PORTS - 1)) ? 3'd0 : win + 3'd1;
      end
    end
    if (out_rdy[P_L]) eject_d = out_flit[P_L];
  end

  // A slot that empties this edge is only refilled on the next one.
  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i])                                slot_d[i] = '0;
      else if (!slot_q[i][VLD] && in_flit[i][VLD]) slot_d[i] = in_flit[i];
    end
  end

  always_ff @(posedge clk1) begin
    // NOTE: sequential state uses '<='; the slots are reset because their
    // valid bit is the occupancy flag, not just data.
    if (rst) begin
      slot_q  <= '{default: '0};
      ptr_q   <= '{default: 3'd0};
      eject_q <= '0;
    end else begin
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      eject_q <= eject_d;
    end
  end

endmodule

// File: rtl/noc_nxn_mesh.sv
// 4x4 mesh top: builds the router array, wires neighbour links and folds the
// per-node PE ports into flat vectors.
module noc_nxn_mesh
  import noc_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] router_in00, router_in01, router_in02, router_in03,
                               router_in10, router_in11, router_in12, router_in13,
                               router_in20, router_in21, router_in22, router_in23,
                               router_in30, router_in31, router_in32, router_in33,
  input  logic                 buffer_in00, buffer_in01, buffer_in02, buffer_in03,
                               buffer_in10, buffer_in11, buffer_in12, buffer_in13,
                               buffer_in20, buffer_in21, buffer_in22, buffer_in23,
                               buffer_in30, buffer_in31, buffer_in32, buffer_in33,
  output logic                 buffer_out00, buffer_out01, buffer_out02, buffer_out03,
                               buffer_out10, buffer_out11, buffer_out12, buffer_out13,
                               buffer_out20, buffer_out21, buffer_out22, buffer_out23,
                               buffer_out30, buffer_out31, buffer_out32, buffer_out33,
  output logic [BUS_WIDTH-1:0] router_out00, router_out01, router_out02, router_out03,
                               router_out10, router_out11, router_out12, router_out13,
                               router_out20, router_out21, router_out22, router_out23,
                               router_out30, router_out31, router_out32, router_out33
);

  logic [NODES*BUS_WIDTH-1:0] rin_flat;
  logic [NODES*BUS_WIDTH-1:0] rout_flat;
  logic [NODES-1:0]           bin_flat;
  logic [NODES-1:0]           bout_flat;

  assign rin_flat = {router_in33, router_in32, router_in31, router_in30,
                     router_in23, router_in22, router_in21, router_in20,
                     router_in13, router_in12, router_in11, router_in10,
                     router_in03, router_in02, router_in01, router_in00};
  assign bin_flat = {buffer_in33, buffer_in32, buffer_in31, buffer_in30,
                     buffer_in23, buffer_in22, buffer_in21, buffer_in20,
                     buffer_in13, buffer_in12, buffer_in11, buffer_in10,
                     buffer_in03, buffer_in02, buffer_in01, buffer_in00};
  assign {router_out33, router_out32, router_out31, router_out30,
          router_out23, router_out22, router_out21, router_out20,
          router_out13, router_out12, router_out11, router_out10,
          router_out03, router_out02, router_out01, router_out00} = rout_flat;
  assign {buffer_out33, buffer_out32, buffer_out31, buffer_out30,
          buffer_out23, buffer_out22, buffer_out21, buffer_out20,
          buffer_out13, buffer_out12, buffer_out11, buffer_out10,
          buffer_out03, buffer_out02, buffer_out01, buffer_out00} = bout_flat;

  noc_link_if #(.W(BUS_WIDTH)) link_if [NODES*(NUM_PORTS-1)] ();

  for (genvar r = 0; r < MESH; r++) begin : g_row
    for (genvar c = 0; c < MESH; c++) begin : g_col
      localparam int IDX = r * MESH + c;
      // Edge ports loop back onto the node's own outgoing link; XY routing
      // never sends off-mesh, so that link only ever carries an empty flit.
      localparam int IN_N = (r > 0)        ? link_idx(IDX - MESH, P_S) : link_idx(IDX, P_N);
      localparam int IN_S = (r < MESH - 1) ? link_idx(IDX + MESH, P_N) : link_idx(IDX, P_S);
      localparam int IN_W = (c > 0)        ? link_idx(IDX - 1, P_E)    : link_idx(IDX, P_W);
      localparam int IN_E = (c < MESH - 1) ? link_idx(IDX + 1, P_W)    : link_idx(IDX, P_E);

      noc_link_if #(.W(BUS_WIDTH)) pe_in  ();
      noc_link_if #(.W(BUS_WIDTH)) pe_out ();

      assign pe_in.flit                           = rin_flat[IDX*BUS_WIDTH +: BUS_WIDTH];
      assign bout_flat[IDX]                       = ~pe_in.ready;
      assign pe_out.ready                         = ~bin_flat[IDX];
      assign rout_flat[IDX*BUS_WIDTH +: BUS_WIDTH] = pe_out.flit;

      noc_router #(.ROW(r), .COL(c), .BUS_WIDTH(BUS_WIDTH)) u_router (
        .clk1  (clk1),
        .rst   (rst),
        .in_l  (pe_in),
        .in_n  (link_if[IN_N]),
        .in_e  (link_if[IN_E]),
        .in_s  (link_if[IN_S]),
        .in_w  (link_if[IN_W]),
        .out_l (pe_out),
        .out_n (link_if[link_idx(IDX, P_N)]),
        .out_e (link_if[link_idx(IDX, P_E)]),
        .out_s (link_if[link_idx(IDX, P_S)]),
        .out_w (link_if[link_idx(IDX, P_W)])
      );
    end
  end

endmodule

// File: tb/tb_noc_nxn_mesh.sv
// Directed bench for the 4x4 mesh: stimulus pushes expected ejections into a
// scoreboard; a negedge monitor pops and compares data and arrival edge.
module tb_noc_nxn_mesh;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] rin  [16];
  logic [31:0] rout [16];
  logic        bin  [16];
  logic        bout [16];

  typedef struct {
    int          node;
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic stall_prev [16];

  noc_nxn_mesh #(.BUS_WIDTH(32)) dut (
    .clk1(clk1), .rst(rst),
    .router_in00(rin[0]),  .router_in01(rin[1]),  .router_in02(rin[2]),  .router_in03(rin[3]),
    .router_in10(rin[4]),  .router_in11(rin[5]),  .router_in12(rin[6]),  .router_in13(rin[7]),
    .router_in20(rin[8]),  .router_in21(rin[9]),  .router_in22(rin[10]), .router_in23(rin[11]),
    .router_in30(rin[12]), .router_in31(rin[13]), .router_in32(rin[14]), .router_in33(rin[15]),
    .buffer_in00(bin[0]),  .buffer_in01(bin[1]),  .buffer_in02(bin[2]),  .buffer_in03(bin[3]),
    .buffer_in10(bin[4]),  .buffer_in11(bin[5]),  .buffer_in12(bin[6]),  .buffer_in13(bin[7]),
    .buffer_in20(bin[8]),  .buffer_in21(bin[9]),  .buffer_in22(bin[10]), .buffer_in23(bin[11]),
    .buffer_in30(bin[12]), .buffer_in31(bin[13]), .buffer_in32(bin[14]), .buffer_in33(bin[15]),
    .buffer_out00(bout[0]),  .buffer_out01(bout[1]),  .buffer_out02(bout[2]),  .buffer_out03(bout[3]),
    .buffer_out10(bout[4]),  .buffer_out11(bout[5]),  .buffer_out12(bout[6]),  .buffer_out13(bout[7]),
    .buffer_out20(bout[8]),  .buffer_out21(bout[9]),  .buffer_out22(bout[10]), .buffer_out23(bout[11]),
    .buffer_out30(bout[12]), .buffer_out31(bout[13]), .buffer_out32(bout[14]), .buffer_out33(bout[15]),
    .router_out00(rout[0]),  .router_out01(rout[1]),  .router_out02(rout[2]),  .router_out03(rout[3]),
    .router_out10(rout[4]),  .router_out11(rout[5]),  .router_out12(rout[6]),  .router_out13(rout[7]),
    .router_out20(rout[8]),  .router_out21(rout[9]),  .router_out22(rout[10]), .router_out23(rout[11]),
    .router_out30(rout[12]), .router_out31(rout[13]), .router_out32(rout[14]), .router_out33(rout[15])
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_out(input int node, input logic [31:0] data, input int exp_cyc);
    sb.push_back('{node: node, data: data, exp_cyc: exp_cyc});
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read at negedge.
  task automatic step();
    @(posedge clk1);
    #2;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      step();
      k++;
    end
    check("drain_scoreboard", sb.size(), 0);
    repeat (3) step();
  endtask

  // A fresh flit is on router_out only when the previous edge saw buffer_in = 0.
  always @(negedge clk1) begin
    for (int n = 0; n < 16; n++) begin
      if (!stall_prev[n] && rout[n][31] === 1'b1) begin
        int hit;
        hit = -1;
        for (int j = 0; j < sb.size(); j++)
          if (hit < 0 && sb[j].node == n) hit = j;
        if (hit < 0) begin
          check($sformatf("unexpected_out%0d%0d", n / 4, n % 4), rout[n], 32'h0);
        end else begin
          check($sformatf("out%0d%0d_data", n / 4, n % 4), rout[n], sb[hit].data);
          check($sformatf("out%0d%0d_edge", n / 4, n % 4), cyc, sb[hit].exp_cyc);
          sb.delete(hit);
        end
      end
      stall_prev[n] = bin[n];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] acc;
    logic [31:0] bacc;
    int          cap;
    int          k;

    for (int i = 0; i < 16; i++) begin
      rin[i]        = $urandom();
      bin[i]        = 1'($urandom_range(0, 1));
      stall_prev[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #2;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("reset_rout%0d", i), rout[i], 32'h0);
      check($sformatf("reset_bout%0d", i), 32'(bout[i]), 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rin[i] = 32'h0;
      bin[i] = 1'b0;
    end

    // Corner to corner 00 -> 33: six hops, out 7 edges after capture.
    step();
    rin[0] = 32'hF80000AB;
    cap    = cyc + 1;
    expect_out(15, 32'hF80000AB, cap + 7);
    step();
    rin[0] = 32'h0;
    drain(40);

    // Self-addressed at node 12.
    step();
    rin[6] = 32'hB0000055;
    cap    = cyc + 1;
    expect_out(6, 32'hB0000055, cap + 1);
    step();
    rin[6] = 32'h0;
    drain(20);

    // Invalid flit held at node 11: nothing moves, slot never fills.
    step();
    rin[5] = 32'h7FFFFFFF;
    repeat (10) begin
      step();
      acc = 32'h0;
      for (int i = 0; i < 16; i++) acc |= rout[i];
      check("invalid_all_rout_zero", acc, 32'h0);
      check("invalid_bout11", 32'(bout[5]), 32'h0);
    end
    rin[5] = 32'h0;

    // Backpressure at node 22 with two flits from node 21.
    bin[10] = 1'b1;
    step();
    rin[9] = 32'hD0000001;
    step();
    rin[9] = 32'h0;
    k = 0;
    while (bout[9] && k < 20) begin
      step();
      k++;
    end
    check("bp_inject_slot_free", 32'(bout[9]), 32'h0);
    rin[9] = 32'hD0000002;
    step();
    rin[9] = 32'h0;
    repeat (4) step();
    check("bp_out22_hold", rout[10], 32'h0);
    check("bp_bout21_full", 32'(bout[9]), 32'h1);
    bin[10] = 1'b0;
    expect_out(10, 32'hD0000001, cyc + 1);
    expect_out(10, 32'hD0000002, cyc + 3);
    drain(20);
    check("bp_bout21_clear", 32'(bout[9]), 32'h0);

    // Contention at node 22: N input (from 02) beats W input (from 20).
    step();
    rin[8] = 32'hD0000AAA;
    rin[2] = 32'hD0000BBB;
    cap    = cyc + 1;
    expect_out(10, 32'hD0000BBB, cap + 3);
    expect_out(10, 32'hD0000AAA, cap + 4);
    step();
    rin[8] = 32'h0;
    rin[2] = 32'h0;
    drain(20);

    // Reset mid-flight discards the flit in the mesh.
    step();
    rin[0] = 32'hF80000AB;
    step();
    rin[0] = 32'h0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    acc  = 32'h0;
    bacc = 32'h0;
    repeat (12) begin
      step();
      for (int i = 0; i < 16; i++) begin
        acc  |= rout[i];
        bacc |= 32'(bout[i]);
      end
    end
    check("midreset_rout_zero", acc, 32'h0);
    check("midreset_bout_zero", bacc, 32'h0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
